pe_depacketizer: RTL and testbench
==================================

# pe_depacketizer

Clocked receive stage directly upstream of the PE's ifmap and filter memories. It accepts 57-bit NoC packets from the router port and checks the header. It unpacks the 40-bit payload into byte-wide writes to the ifmap or filter memory, using per-memory auto-incrementing write pointers. Once both memories are full and a control packet arrives, it issues a single start handshake to the PE datapath.

## Interface
- PKT_W, 57, packet width
- DATA_W, 40, payload width (five bytes)
- WIDTH, 8, memory word width
- DEPTH_I, 5, ifmap memory depth
- DEPTH_F, 5, filter memory depth
- ADDR_W, 3, memory address width
- MY_ADDR, 4'h2, this PE's NoC address
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pkt_in_valid  in  1  packet valid from router
- pkt_in_ready  out  1  block can accept a packet
- pkt_in_data  in  PKT_W  packet
- mem_wr_en  out  1  write strobe, one byte per cycle
- mem_wr_sel  out  1  0 = ifmap, 1 = filter
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  WIDTH  write byte
- start_valid  out  1  start request to PE
- start_ready  in  1  PE accepts start
- loaded_ifmap, loaded_filter  out  1 each  memory full flags
- err_drop  out  1  one-cycle pulse when a packet is discarded
- err_ovf  out  1  sticky overflow flag

## Operation
- Packet fields: [56:55] type (0 ifmap, 1 filter, 2 ctrl, 3 illegal); [54:51] src; [50:47] dst; [46:45] hop; [44:42] len; [41:40] reserved (ignored); [39:0] payload.
- Byte k of the payload is payload[8k+7:8k]. Bytes are written in ascending k.
- FSM states:
  - IDLE: pkt_in_ready=1. On valid&ready, latch the packet, then decode it.
  - UNPACK: write one byte per cycle, k = 0..len-1, then go to IDLE.
  - START: start_valid=1 until start_ready, then go to IDLE.
- Decode on accept:
  - type 0 or 1 with len 1..5 → UNPACK.
  - len 0 or len > 5, or type 3 → err_drop, stay in IDLE.
  - type 2 with loaded_ifmap & loaded_filter → START.
  - type 2 otherwise → err_drop, stay in IDLE.
- Write pointers wp_i and wp_f (ADDR_W+1 bits) start at 0.
  - Each byte goes to the selected memory at address wp, then wp increments.
  - loaded_x = (wp_x == DEPTH_x).
- Full memory: when wp_x == DEPTH_x, the byte is not written (mem_wr_en=0), wp holds, and err_ovf is set. The UNPACK cycle is still consumed. There is no wrap-around.
- Start handshake (start_valid & start_ready): clear wp_i, wp_f and err_ovf in the same edge. The loaded flags fall in the next cycle.
- Reset values: all outputs 0, pointers 0, state IDLE. pkt_in_ready is 0 during reset and 1 from the first cycle after release.
- Reset mid-UNPACK or mid-START aborts immediately. The partial packet is lost and the pointers clear.

## Timing
- Accept at edge E → byte 0 write strobe in cycle E+1 → byte len-1 in cycle E+len.
- pkt_in_ready re-asserts in cycle E+len+1. Throughput is one packet per len+1 cycles.
- err_drop is high exactly in cycle E+1.
- For a ctrl packet, start_valid rises in cycle E+1 and must hold stable until start_ready is sampled high.
- pkt_in_data is sampled only on the accept edge. Changing it afterwards has no effect.
- All outputs are registered; there are no combinational input→output paths except none.

## Configuration
- PE_DEPKT_ADDR_CHECK_EN defined: a packet with dst != MY_ADDR is discarded at accept, with an err_drop pulse and no writes. This applies to every type.
- PE_DEPKT_ADDR_CHECK_EN undefined: dst is ignored and all packets are processed.

## Structure
- Shared package `noc_pkg` holds:
  - field bit positions and widths (TYPE, SRC, DST, HOP, LEN, PAYLOAD);
  - the `pkt_type_e` enum (IFMAP, FILTER, CTRL, ILLEGAL);
  - a packed `noc_pkt_t` struct.
- One sub-module, `pe_wr_ptr`, is instantiated twice. It contains the pointer, the full flag, the increment and the clear.

## Test plan
- ifmap packet (type 0, dst 2, len 5, payload 0x0504030201) → writes 01,02,03,04,05 to ifmap addresses 0..4 in cycles E+1..E+5; loaded_ifmap=1 afterwards.
- filter packet with len 3 (payload 0x..1F0A07), then len 2 (0x..0908) → filter addresses 0..4 receive 07,0A,1F,08,09; loaded_filter=1.
- ctrl packet before the memories are loaded → err_drop pulse and no start_valid. The same ctrl packet after both memories are loaded → start_valid held through 3 cycles of start_ready=0. Handshake then clears pointers and flags.
- Sixth ifmap byte (second packet, len 1, while full) → no write strobe, err_ovf=1, cleared by the next start handshake.
- With PE_DEPKT_ADDR_CHECK_EN, a dst=7 packet → err_drop and no writes. Without the macro, the same packet is written normally. len=0 and len=6 → err_drop in both builds.
- rst_n low during byte 2 of an UNPACK → outputs 0 immediately, pointers 0, pkt_in_ready=1 after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: field positions, packet type encoding and
// the packed packet layout used by the PE depacketizer.
package noc_pkg;

  localparam int TYPE_LSB    = 55;
  localparam int TYPE_W      = 2;
  localparam int SRC_LSB     = 51;
  localparam int SRC_W       = 4;
  localparam int DST_LSB     = 47;
  localparam int DST_W       = 4;
  localparam int HOP_LSB     = 45;
  localparam int HOP_W       = 2;
  localparam int LEN_LSB     = 42;
  localparam int LEN_W       = 3;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 40;
  localparam int MAX_LEN     = PAYLOAD_W / 8;

  typedef enum logic [TYPE_W-1:0] {
    PKT_IFMAP   = 2'd0,
    PKT_FILTER  = 2'd1,
    PKT_CTRL    = 2'd2,
    PKT_ILLEGAL = 2'd3
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e            typ;
    logic [SRC_W-1:0]     src;
    logic [DST_W-1:0]     dst;
    logic [HOP_W-1:0]     hop;
    logic [LEN_W-1:0]     len;
    logic [1:0]           rsvd;
    logic [PAYLOAD_W-1:0] payload;
  } noc_pkt_t;

  // A length is usable when it names at least one and at most all payload bytes.
  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/pe_wr_ptr.sv
// Auto-incrementing write pointer for one PE memory, with full flag and clear.
module pe_wr_ptr #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              full
);

  logic [ADDR_W:0] wp;

  // Pointer advances per written byte; clear wins so a start handshake always rewinds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
    end else if (clr) begin
      wp <= '0;
    end else if (inc && !full) begin
      wp <= wp + 1'b1;
    end
  end

  assign full = (wp == (ADDR_W+1)'(DEPTH));
  assign addr = wp[ADDR_W-1:0];

endmodule

// File: rtl/pe_depacketizer.sv
// PE receive stage: header check, byte-wise unpack into ifmap/filter memory,
// start handshake once both memories are loaded.
// Optional build macro PE_DEPKT_ADDR_CHECK_EN: discard packets whose dst
// differs from MY_ADDR.
module pe_depacketizer
  import noc_pkg::*;
#(
  parameter int         PKT_W   = 57,
  parameter int         DATA_W  = 40,
  parameter int         WIDTH   = 8,
  parameter int         DEPTH_I = 5,
  parameter int         DEPTH_F = 5,
  parameter int         ADDR_W  = 3,
  parameter logic [3:0] MY_ADDR = 4'h2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_in_valid,
  output logic              pkt_in_ready,
  input  logic [PKT_W-1:0]  pkt_in_data,
  output logic              mem_wr_en,
  output logic              mem_wr_sel,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              start_valid,
  input  logic              start_ready,
  output logic              loaded_ifmap,
  output logic              loaded_filter,
  output logic              err_drop,
  output logic              err_ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UNPACK = 2'd1;
  localparam logic [1:0] S_START  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] payload_q;
  logic [LEN_W-1:0]  rem;
  logic              sel_q;

  noc_pkt_t          pkt;
  logic              accept, dst_ok, is_data, go_unpack, go_start, go_drop, handshake;
  logic              emit, emit_sel, emit_full;
  logic [WIDTH-1:0]  emit_byte;
  logic [ADDR_W-1:0] addr_i, addr_f;
  logic              inc_i, inc_f;
  logic              unused_fields;

  assign pkt = noc_pkt_t'(pkt_in_data);
  assign unused_fields = ^{pkt.src, pkt.hop, pkt.rsvd, pkt.dst, MY_ADDR};

`ifdef PE_DEPKT_ADDR_CHECK_EN
  assign dst_ok = (pkt.dst == MY_ADDR);
`else
  assign dst_ok = 1'b1;
`endif

  assign accept    = pkt_in_valid & pkt_in_ready;
  assign is_data   = (pkt.typ == PKT_IFMAP) || (pkt.typ == PKT_FILTER);
  assign go_unpack = accept & dst_ok & len_ok(pkt.len) & is_data;
  assign go_start  = accept & dst_ok & len_ok(pkt.len) & (pkt.typ == PKT_CTRL)
                   & loaded_ifmap & loaded_filter;
  assign go_drop   = accept & ~go_unpack & ~go_start;
  assign handshake = start_valid & start_ready;

  // Byte 0 is taken straight from the accepted packet; later bytes from the shifted latch.
  always_comb begin
    emit      = 1'b0;
    emit_sel  = sel_q;
    emit_byte = payload_q[WIDTH-1:0];
    if (go_unpack) begin
      emit      = 1'b1;
      emit_sel  = (pkt.typ == PKT_FILTER);
      emit_byte = pkt.payload[WIDTH-1:0];
    end else if (state == S_UNPACK && rem != '0) begin
      emit = 1'b1;
    end
  end

  assign emit_full = emit_sel ? loaded_filter : loaded_ifmap;
  assign inc_i     = emit & ~emit_sel & ~loaded_ifmap;
  assign inc_f     = emit &  emit_sel & ~loaded_filter;

  pe_wr_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH_I)) u_ptr_ifmap (
    .clk(clk), .rst_n(rst_n), .inc(inc_i), .clr(handshake),
    .addr(addr_i), .full(loaded_ifmap)
  );

  pe_wr_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH_F)) u_ptr_filter (
    .clk(clk), .rst_n(rst_n), .inc(inc_f), .clr(handshake),
    .addr(addr_f), .full(loaded_filter)
  );

  // Registered write port, error flags and packet sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      payload_q    <= '0;
      rem          <= '0;
      sel_q        <= 1'b0;
      pkt_in_ready <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_sel   <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      start_valid  <= 1'b0;
      err_drop     <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      err_drop  <= go_drop;
      mem_wr_en <= emit & ~emit_full;
      if (emit) begin
        mem_wr_sel  <= emit_sel;
        mem_wr_addr <= emit_sel ? addr_f : addr_i;
        mem_wr_data <= emit_byte;
      end
      if (handshake) begin
        err_ovf <= 1'b0;
      end else if (emit && emit_full) begin
        err_ovf <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          pkt_in_ready <= 1'b1;
          if (go_unpack) begin
            state        <= S_UNPACK;
            pkt_in_ready <= 1'b0;
            sel_q        <= (pkt.typ == PKT_FILTER);
            rem          <= pkt.len - 1'b1;
            payload_q    <= pkt.payload >> WIDTH;
          end else if (go_start) begin
            state        <= S_START;
            pkt_in_ready <= 1'b0;
            start_valid  <= 1'b1;
          end
        end
        S_UNPACK: begin
          if (rem != '0) begin
            rem       <= rem - 1'b1;
            payload_q <= payload_q >> WIDTH;
          end else begin
            state        <= S_IDLE;
            pkt_in_ready <= 1'b1;
          end
        end
        S_START: begin
          if (start_ready) begin
            state        <= S_IDLE;
            start_valid  <= 1'b0;
            pkt_in_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_depacketizer.sv
// Self-checking bench for pe_depacketizer: directed test-plan steps followed
// by randomized packets, checked against a memory/pointer model of the PE.
module tb_pe_depacketizer;

  localparam int DEPTH = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_in_valid = 1'b0;
  logic        pkt_in_ready;
  logic [56:0] pkt_in_data = '0;
  logic        mem_wr_en, mem_wr_sel;
  logic [2:0]  mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        start_valid;
  logic        start_ready = 1'b0;
  logic        loaded_ifmap, loaded_filter, err_drop, err_ovf;

  int checks = 0;
  int errors = 0;
  int m_wp[2];
  bit m_ovf;

  pe_depacketizer dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready), .pkt_in_data(pkt_in_data),
    .mem_wr_en(mem_wr_en), .mem_wr_sel(mem_wr_sel), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .start_valid(start_valid), .start_ready(start_ready),
    .loaded_ifmap(loaded_ifmap), .loaded_filter(loaded_filter),
    .err_drop(err_drop), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dst_accepted(input logic [3:0] dst);
`ifdef PE_DEPKT_ADDR_CHECK_EN
    return dst == 4'h2;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(pkt_in_ready), 64'(1));
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'(0));
    chk({tag, "_err_ovf"}, 64'(err_ovf), 64'(m_ovf));
    chk({tag, "_loaded_i"}, 64'(loaded_ifmap), 64'(m_wp[0] == DEPTH));
    chk({tag, "_loaded_f"}, 64'(loaded_filter), 64'(m_wp[1] == DEPTH));
  endtask

  // Present one packet, then follow it cycle by cycle against the model.
  task automatic send(input logic [1:0] typ, input logic [3:0] dst, input logic [2:0] len,
                      input logic [39:0] payload, input int hs_delay);
    int  n;
    int  sel;
    bit  drop;
    bit  both;
    n = 0;
    while (pkt_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(pkt_in_ready), 64'(1));
    pkt_in_data  = {typ, 4'($urandom), dst, 2'($urandom), len, 2'($urandom), payload};
    pkt_in_valid = 1'b1;
    @(posedge clk);
    #1;
    pkt_in_valid = 1'b0;
    pkt_in_data  = 57'({$urandom, $urandom});
    both = (m_wp[0] == DEPTH) && (m_wp[1] == DEPTH);
    drop = !dst_accepted(dst) || typ == 2'd3 || len == 3'd0 || len > 3'd5 ||
           (typ == 2'd2 && !both);
    @(negedge clk);
    chk("err_drop", 64'(err_drop), 64'(drop));
    if (drop) begin
      chk("drop_wr_en", 64'(mem_wr_en), 64'(0));
      chk("drop_start", 64'(start_valid), 64'(0));
      chk("drop_ready", 64'(pkt_in_ready), 64'(1));
      @(negedge clk);
      chk("drop_pulse_end", 64'(err_drop), 64'(0));
    end else if (typ == 2'd2) begin
      chk("start_rise", 64'(start_valid), 64'(1));
      chk("start_ready_low", 64'(pkt_in_ready), 64'(0));
      for (int i = 0; i < hs_delay; i++) begin
        @(negedge clk);
        chk("start_hold", 64'(start_valid), 64'(1));
      end
      start_ready = 1'b1;
      @(negedge clk);
      start_ready = 1'b0;
      m_wp[0] = 0;
      m_wp[1] = 0;
      m_ovf   = 1'b0;
      chk("start_done", 64'(start_valid), 64'(0));
      check_idle_outputs("after_start");
    end else begin
      sel = (typ == 2'd1) ? 1 : 0;
      for (int k = 0; k < int'(len); k++) begin
        if (k > 0) @(negedge clk);
        chk("unpack_ready", 64'(pkt_in_ready), 64'(0));
        if (m_wp[sel] < DEPTH) begin
          chk("wr_en", 64'(mem_wr_en), 64'(1));
          chk("wr_sel", 64'(mem_wr_sel), 64'(sel));
          chk("wr_addr", 64'(mem_wr_addr), 64'(m_wp[sel]));
          chk("wr_data", 64'(mem_wr_data), 64'(payload[8*k +: 8]));
          m_wp[sel]++;
        end else begin
          m_ovf = 1'b1;
          chk("ovf_no_write", 64'(mem_wr_en), 64'(0));
          chk("ovf_flag", 64'(err_ovf), 64'(1));
        end
      end
      @(negedge clk);
      check_idle_outputs("after_unpack");
    end
  endtask

  initial begin
    logic [39:0] pl;
    int          r;
    logic [1:0]  t;
    m_wp[0] = 0;
    m_wp[1] = 0;
    m_ovf   = 1'b0;

    #1;
    chk("rst_ready", 64'(pkt_in_ready), 64'(0));
    chk("rst_outs", 64'({mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data, start_valid,
                        loaded_ifmap, loaded_filter, err_drop, err_ovf}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_low_at_release", 64'(pkt_in_ready), 64'(0));
    @(negedge clk);
    check_idle_outputs("post_reset");

    send(2'd2, 4'h2, 3'd1, 40'h0, 0);
    send(2'd0, 4'h2, 3'd5, 40'h05_0403_0201, 0);
    send(2'd1, 4'h2, 3'd3, {16'($urandom), 24'h1F0A07}, 0);
    send(2'd1, 4'h2, 3'd2, {24'($urandom), 16'h0908}, 0);
    send(2'd0, 4'h2, 3'd1, 40'h0000_0000_66, 0);
    send(2'd0, 4'h2, 3'd0, 40'h11, 0);
    send(2'd0, 4'h2, 3'd6, 40'h22, 0);
    send(2'd3, 4'h2, 3'd2, 40'h33, 0);
    send(2'd2, 4'h2, 3'd1, 40'h0, 3);
    send(2'd0, 4'h7, 3'd2, 40'h0000_00BE_EF, 0);

    // Reset while the third byte of a five-byte packet is on the write port.
    pkt_in_data  = {2'd0, 4'h1, 4'h2, 2'd0, 3'd5, 2'd0, 40'hAA_BBCC_DDEE};
    pkt_in_valid = 1'b1;
    @(posedge clk);
    #1;
    pkt_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_unpack_wr_en", 64'(mem_wr_en), 64'(1));
    chk("mid_unpack_data", 64'(mem_wr_data), 64'(8'hCC));
    chk("mid_unpack_addr", 64'(mem_wr_addr), 64'(m_wp[0] + 2));
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 64'({pkt_in_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
                          start_valid, loaded_ifmap, loaded_filter, err_drop, err_ovf}), 64'(0));
    m_wp[0] = 0;
    m_wp[1] = 0;
    m_ovf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_abort");
    send(2'd0, 4'h2, 3'd1, 40'h5A, 0);

    for (int p = 0; p < 60; p++) begin
      r  = int'($urandom_range(0, 9));
      t  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      pl = {8'($urandom), 32'($urandom)};
      send(t, ($urandom_range(0, 7) == 0) ? 4'h7 : 4'h2,
           ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5)),
           pl, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
